fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the 32-entry instruction memory and feeds the decode stage. It owns the program counter, drives the word address into the instruction memory, and captures the returned instruction into an IF/ID pipeline register with a valid flag. It supports downstream stall, branch/jump redirect with squash, and a halt-on-marker state.

## Interface
Parameters:
- PC_W, 5, program-counter width; word index into instruction memory (32 words)
- INSTR_W, 32, instruction width
- RESET_PC, 5'd0, PC value loaded on reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- pc  out  PC_W  word address to instruction memory
- instr  in  INSTR_W  instruction returned by memory for current pc (combinational read, same cycle)
- stall  in  1  decode not ready; hold PC and IF/ID register
- redirect  in  1  branch/jump taken; load redirect_pc, squash in-flight fetch
- redirect_pc  in  PC_W  redirect target
- if_valid  out  1  IF/ID register holds a live instruction
- if_instr  out  INSTR_W  captured instruction
- if_pc  out  PC_W  address of captured instruction
- halted  out  1  fetch stopped on HALT_WORD

## Operation
- States: INIT, RUN, HALT.
- Reset (reset=1 at edge): state=INIT, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, halted=0. Reset overrides every other input.
- INIT: one bubble cycle so instruction memory contents are settled after reset deasserts; no capture, pc holds; INIT->RUN unconditionally.
- RUN, per cycle, priority redirect > stall > normal:
  - redirect=1: pc<=redirect_pc; if_valid<=0; if_instr/if_pc hold. Applies even with stall=1.
  - stall=1 (no redirect): pc, if_valid, if_instr, if_pc all hold.
  - normal, instr!=HALT_WORD: if_instr<=instr, if_pc<=pc, if_valid<=1, pc<=pc+1 modulo 2^PC_W (31 wraps to 0).
  - normal, instr==HALT_WORD: if_valid<=0, pc holds, halted<=1, state->HALT. Halt word is never presented as valid.
- HALT: pc holds, if_valid=0, halted=1; stall ignored. redirect=1 -> state RUN, pc<=redirect_pc, halted<=0.
- No other state changes; INIT ignores stall and redirect.

## Timing
- pc->if_instr latency: 1 cycle (instruction read combinationally, registered at next edge).
- First if_valid=1: second rising edge after the edge at which reset is sampled low (INIT bubble + one fetch).
- Throughput: one instruction per cycle without stall/redirect.
- Redirect: target instruction appears in IF/ID 2 edges after redirect is sampled; exactly one bubble (if_valid=0) in between.
- Stall: if_* outputs stable for every stalled cycle; resumes next cycle after stall falls with no lost or duplicated instruction.
- Reset mid-operation: all outputs take reset values at that edge, regardless of state, stall or redirect.

## Structure
- Package fetch_pkg: state enum (INIT, RUN, HALT), PC_W, INSTR_W, HALT_WORD defaults.
- One sub-module natural: if_id_reg (instr, pc, valid with load/hold/clear controls); PC register, next-PC mux and FSM in fetch_unit.

## Test plan
- Reset then run with memory {0x00000200, 0x00000201, 0x00000204, 0x00000108}: if_valid rises 2 edges after reset release; if_instr sequence 0x200, 0x201, 0x204, 0x108 with if_pc 0,1,2,3.
- stall=1 for 3 cycles while if_instr=0x201: if_instr/if_pc/pc unchanged; after release next if_instr=0x204, no duplicate of 0x201.
- redirect=1, redirect_pc=1 while pc=3: next cycle if_valid=0; following cycle if_instr=0x201, if_pc=1. Repeat with stall=1 simultaneous: identical result.
- Place HALT_WORD at address 4: after 0x108, halted=1, if_valid=0, pc stays 4; stall toggling has no effect; redirect to 0 restarts with if_instr=0x200, halted=0.
- Free run from pc=30 with non-halt words: if_pc 30, 31, 0, 1 (wrap).
- Assert reset while in RUN with stall=1 and redirect=1: all outputs return to reset values; INIT bubble repeats.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch stage.
package fetch_pkg;

    localparam int PC_W = 5;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captured instruction, its address and a valid flag.
// Load captures new contents. Clear drops valid but keeps the payload. Otherwise the register holds.
module if_id_reg #(
    parameter int PC_W    = fetch_pkg::PC_W,
    parameter int INSTR_W = fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and INIT/RUN/HALT control.
// It drives the IF/ID register that feeds decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                     PC_W      = fetch_pkg::PC_W,
    parameter int                     INSTR_W   = fetch_pkg::INSTR_W,
    parameter logic [PC_W-1:0]        RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]     HALT_WORD = fetch_pkg::HALT_WORD
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               halted
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            load, clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INIT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        halted_d = halted_q;
        load     = 1'b0;
        clear    = 1'b0;
        case (state_q)
            // The bubble lets memory contents settle after reset; stall and redirect are ignored.
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (redirect) begin
                    pc_d  = redirect_pc;
                    clear = 1'b1;
                end else if (!stall) begin
                    if (instr == HALT_WORD) begin
                        clear    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        load = 1'b1;
                        pc_d = pc_q + PC_ONE;
                    end
                end
            end
            ST_HALT: begin
                clear = 1'b1;
                if (redirect) begin
                    pc_d     = redirect_pc;
                    halted_d = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    if_id_reg #(
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .clear_i (clear),
        .instr_i (instr),
        .pc_i    (pc_q),
        .valid_o (if_valid),
        .instr_o (if_instr),
        .pc_o    (if_pc)
    );

    assign pc     = pc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. A 32-word combinational memory model sits behind pc.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pc;
    logic [31:0] instr;
    logic        stall;
    logic        redirect;
    logic [4:0]  redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [4:0]  if_pc;
    logic        halted;

    logic [31:0] mem [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign instr = mem[pc];

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .instr       (instr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_if(input string tag, input logic v, input logic [31:0] ins,
                             input logic [4:0] ipc, input logic [4:0] p, input logic h);
        check({tag, ".valid"},  32'(if_valid), 32'(v));
        check({tag, ".instr"},  if_instr, ins);
        check({tag, ".if_pc"},  32'(if_pc), 32'(ipc));
        check({tag, ".pc"},     32'(pc), 32'(p));
        check({tag, ".halted"}, 32'(halted), 32'(h));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0000_1000 + 32'(i);
        mem[0]  = 32'h0000_0200;
        mem[1]  = 32'h0000_0201;
        mem[2]  = 32'h0000_0204;
        mem[3]  = 32'h0000_0108;
        mem[4]  = 32'hFFFF_FFFF;
        mem[30] = 32'h0000_0300;
        mem[31] = 32'h0000_0301;

        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        step(); step();
        expect_if("reset", 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);

        // INIT bubble, then the first fetch.
        reset = 1'b0;
        step();
        expect_if("init", 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
        step();
        expect_if("f0", 1'b1, 32'h200, 5'd0, 5'd1, 1'b0);
        step();
        expect_if("f1", 1'b1, 32'h201, 5'd1, 5'd2, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_if("stall", 1'b1, 32'h201, 5'd1, 5'd2, 1'b0);
        end
        stall = 1'b0;
        step();
        expect_if("unstall", 1'b1, 32'h204, 5'd2, 5'd3, 1'b0);

        // Redirect to 1 while pc=3.
        redirect = 1'b1; redirect_pc = 5'd1;
        step();
        expect_if("redir", 1'b0, 32'h204, 5'd2, 5'd1, 1'b0);
        redirect = 1'b0;
        step();
        expect_if("redir_tgt", 1'b1, 32'h201, 5'd1, 5'd2, 1'b0);
        step();
        expect_if("f2", 1'b1, 32'h204, 5'd2, 5'd3, 1'b0);

        // Same redirect with stall held high at the same time.
        redirect = 1'b1; stall = 1'b1;
        step();
        expect_if("redir_st", 1'b0, 32'h204, 5'd2, 5'd1, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step();
        expect_if("redir_st_tgt", 1'b1, 32'h201, 5'd1, 5'd2, 1'b0);
        step();
        expect_if("f2b", 1'b1, 32'h204, 5'd2, 5'd3, 1'b0);
        step();
        expect_if("f3", 1'b1, 32'h108, 5'd3, 5'd4, 1'b0);

        // HALT_WORD sits at address 4.
        step();
        expect_if("halt", 1'b0, 32'h108, 5'd3, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            stall = (i % 2 == 0);
            step();
            expect_if("halt_stall", 1'b0, 32'h108, 5'd3, 5'd4, 1'b1);
        end
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 5'd0;
        step();
        expect_if("unhalt", 1'b0, 32'h108, 5'd3, 5'd0, 1'b0);
        redirect = 1'b0;
        step();
        expect_if("restart", 1'b1, 32'h200, 5'd0, 5'd1, 1'b0);

        // PC wrap from 31 to 0.
        redirect = 1'b1; redirect_pc = 5'd30;
        step();
        expect_if("to30", 1'b0, 32'h200, 5'd0, 5'd30, 1'b0);
        redirect = 1'b0;
        step();
        expect_if("w30", 1'b1, 32'h300, 5'd30, 5'd31, 1'b0);
        step();
        expect_if("w31", 1'b1, 32'h301, 5'd31, 5'd0, 1'b0);
        step();
        expect_if("w0", 1'b1, 32'h200, 5'd0, 5'd1, 1'b0);
        step();
        expect_if("w1", 1'b1, 32'h201, 5'd1, 5'd2, 1'b0);

        // Reset takes priority over stall and redirect.
        reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 5'd5;
        step();
        expect_if("rst_mid", 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
        reset = 1'b0; stall = 1'b0; redirect = 1'b0;
        step();
        expect_if("init2", 1'b0, 32'h0, 5'd0, 5'd0, 1'b0);
        step();
        expect_if("f0_again", 1'b1, 32'h200, 5'd0, 5'd1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
